// File: rtl/sort8_ctrl_pkg.sv
// Shared definitions for the sort8_ctrl block: FSM encodings, comparator width
// and an elaboration-time log2 helper.
package sort8_ctrl_pkg;

    localparam logic [1:0] ST_LOAD   = 2'd0;
    localparam logic [1:0] ST_SORT   = 2'd1;
    localparam logic [1:0] ST_UNLOAD = 2'd2;

    localparam int CMP_W = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/comparator_8bit.sv
// Unsigned magnitude comparator shared by the sort sequencer.
module comparator_8bit
    import sort8_ctrl_pkg::*;
(
    input  logic [CMP_W-1:0] A,
    input  logic [CMP_W-1:0] B,
    output logic             A_less_B,
    output logic             A_equal_B,
    output logic             A_great_B
);

    assign A_less_B  = (A < B);
    assign A_equal_B = (A == B);
    assign A_great_B = (A > B);

endmodule

// File: rtl/sort8_ctrl.sv
// Loads a block of bytes, bubble-sorts it in place with a single shared
// comparator (one compare per cycle) and streams the sorted block out.
module sort8_ctrl
    import sort8_ctrl_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter bit ASCEND = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CMP_W-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CMP_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             done,
    output logic [15:0]      cmp_cnt
);

    localparam int CNT_W = clog2(DEPTH + 1);
    localparam int IDX_W = clog2(DEPTH);

    logic [1:0]       state_reg;
    logic [CNT_W-1:0] wr_reg;
    logic [CNT_W-1:0] n_reg;
    logic [IDX_W-1:0] rd_reg;
    logic [IDX_W-1:0] i_reg;
    logic [IDX_W-1:0] p_reg;
    logic             swapped_reg;
    logic             done_reg;
    logic [15:0]      cmp_cnt_reg;
    logic [CMP_W-1:0] mem [0:DEPTH-1];

    logic [IDX_W-1:0] idx_b;
    logic [CMP_W-1:0] cmp_a;
    logic [CMP_W-1:0] cmp_b;
    logic             a_less_b;
    logic             a_equal_b;
    logic             a_great_b;

    assign idx_b = i_reg + 1'b1;
    assign cmp_a = mem[i_reg];
    assign cmp_b = mem[idx_b];

    comparator_8bit u_cmp (
        .A         (cmp_a),
        .B         (cmp_b),
        .A_less_B  (a_less_b),
        .A_equal_B (a_equal_b),
        .A_great_B (a_great_b)
    );

    logic swap_now;
    logic load_fire;
    logic load_end;
    logic out_fire;
    logic unload_last;
    logic pass_end;
    logic final_pass;
    logic sort_exit;

    // Equal neighbours are never exchanged, which keeps the sort stable.
    assign swap_now    = (state_reg == ST_SORT) && !a_equal_b &&
                         (ASCEND ? a_great_b : a_less_b);
    assign load_fire   = in_valid && in_ready;
    assign load_end    = load_fire && (in_last || (wr_reg == CNT_W'(DEPTH - 1)));
    assign out_fire    = out_valid && out_ready;
    assign unload_last = (CNT_W'(rd_reg) == (n_reg - CNT_W'(1)));
    assign pass_end    = (CNT_W'(i_reg) == (n_reg - CNT_W'(2) - CNT_W'(p_reg)));
    assign final_pass  = (CNT_W'(p_reg) == (n_reg - CNT_W'(2)));
    assign sort_exit   = pass_end && (!(swapped_reg || swap_now) || final_pass);

    assign in_ready  = (state_reg == ST_LOAD);
    assign out_valid = (state_reg == ST_UNLOAD) && (n_reg != '0);
    assign out_data  = out_valid ? mem[rd_reg] : '0;
    assign out_last  = out_valid && unload_last;
    assign busy      = (state_reg == ST_SORT) || (state_reg == ST_UNLOAD);
    assign done      = done_reg;
    assign cmp_cnt   = cmp_cnt_reg;

    // Buffer has no reset; its contents are meaningless outside a block.
    always_ff @(posedge clk) begin
        if (!clear) begin
            if (load_fire) begin
                mem[wr_reg[IDX_W-1:0]] <= in_data;
            end else if (swap_now) begin
                mem[i_reg] <= cmp_b;
                mem[idx_b] <= cmp_a;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_LOAD;
            wr_reg      <= '0;
            n_reg       <= '0;
            rd_reg      <= '0;
            i_reg       <= '0;
            p_reg       <= '0;
            swapped_reg <= 1'b0;
            done_reg    <= 1'b0;
            cmp_cnt_reg <= '0;
        end else if (clear) begin
            state_reg   <= ST_LOAD;
            wr_reg      <= '0;
            n_reg       <= '0;
            rd_reg      <= '0;
            i_reg       <= '0;
            p_reg       <= '0;
            swapped_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_LOAD: begin
                    if (load_fire) begin
                        wr_reg <= wr_reg + 1'b1;
                        if (wr_reg == '0) begin
                            cmp_cnt_reg <= '0;
                        end
                        if (load_end) begin
                            n_reg     <= wr_reg + 1'b1;
                            state_reg <= (wr_reg != '0) ? ST_SORT : ST_UNLOAD;
                        end
                    end
                end
                ST_SORT: begin
                    if (cmp_cnt_reg != 16'hFFFF) begin
                        cmp_cnt_reg <= cmp_cnt_reg + 16'd1;
                    end
                    if (swap_now) begin
                        swapped_reg <= 1'b1;
                    end
                    if (pass_end) begin
                        if (sort_exit) begin
                            state_reg <= ST_UNLOAD;
                        end else begin
                            p_reg       <= p_reg + 1'b1;
                            i_reg       <= '0;
                            swapped_reg <= 1'b0;
                        end
                    end else begin
                        i_reg <= i_reg + 1'b1;
                    end
                end
                ST_UNLOAD: begin
                    if (n_reg == '0) begin
                        state_reg <= ST_LOAD;
                        wr_reg    <= '0;
                        rd_reg    <= '0;
                    end else if (out_fire) begin
                        if (unload_last) begin
                            done_reg    <= 1'b1;
                            state_reg   <= ST_LOAD;
                            wr_reg      <= '0;
                            rd_reg      <= '0;
                            p_reg       <= '0;
                            i_reg       <= '0;
                            swapped_reg <= 1'b0;
                        end else begin
                            rd_reg <= rd_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort8_ctrl.sv
// Directed bench for sort8_ctrl: hand-computed blocks, backpressure,
// depth-limited load, async reset mid-sort and clear mid-unload.
module tb_sort8_ctrl;

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       done;
    logic [15:0] cmp_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    sort8_ctrl #(.DEPTH(8), .ASCEND(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done),
        .cmp_cnt   (cmp_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_block(input byte_q_t din, input bit use_last);
        for (int k = 0; k < din.size(); k++) begin
            in_valid = 1'b1;
            in_data  = din[k];
            in_last  = use_last && (k == din.size() - 1);
            check("in_ready_load", {31'd0, in_ready}, 32'd1);
            tick;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic sort_wait(input int exp_cycles);
        int cycles;
        cycles = 0;
        while (busy && !out_valid && cycles < 200) begin
            check("in_ready_sort", {31'd0, in_ready}, 32'd0);
            tick;
            cycles++;
        end
        check("sort_cycles", cycles, exp_cycles);
    endtask

    task automatic unload_block(input byte_q_t exp, input int stall_at);
        int w;
        out_ready = 1'b1;
        for (int k = 0; k < exp.size(); k++) begin
            w = 0;
            while (!out_valid && w < 50) begin
                tick;
                w++;
            end
            check("out_valid", {31'd0, out_valid}, 32'd1);
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick;
                    check("stall_data", {24'd0, out_data}, {24'd0, exp[k]});
                    check("stall_valid", {31'd0, out_valid}, 32'd1);
                end
                out_ready = 1'b1;
            end
            check("out_data", {24'd0, out_data}, {24'd0, exp[k]});
            check("out_last", {31'd0, out_last}, (k == exp.size() - 1) ? 32'd1 : 32'd0);
            check("in_ready_unload", {31'd0, in_ready}, 32'd0);
            tick;
        end
        out_ready = 1'b0;
        check("done_pulse", {31'd0, done}, 32'd1);
        check("in_ready_after", {31'd0, in_ready}, 32'd1);
        check("busy_after", {31'd0, busy}, 32'd0);
        tick;
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    task automatic run_block(input string name, input byte_q_t din, input byte_q_t exp,
                             input bit use_last, input int exp_cmp, input int exp_cycles,
                             input int stall_at);
        load_block(din, use_last);
        sort_wait(exp_cycles);
        check("cmp_cnt", {16'd0, cmp_cnt}, exp_cmp);
        unload_block(exp, stall_at);
        check("cmp_cnt_kept", {16'd0, cmp_cnt}, exp_cmp);
        $display("block %s: %0d words in, cmp_cnt=%0d, failures so far %0d",
                 name, din.size(), cmp_cnt, n_fail);
    endtask

    initial begin
        tick;
        tick;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cmp_cnt", {16'd0, cmp_cnt}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        rst_n = 1'b1;
        tick;

        run_block("three", '{8'h80, 8'h83, 8'h08}, '{8'h08, 8'h80, 8'h83}, 1'b1, 3, 3, -1);
        run_block("sorted", '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                  '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b1, 7, 7, -1);
        run_block("reverse_bp", '{8'hF8, 8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1},
                  '{8'hF1, 8'hF2, 8'hF3, 8'hF4, 8'hF5, 8'hF6, 8'hF7, 8'hF8}, 1'b1, 28, 28, 3);
        run_block("dups", '{8'h80, 8'h80, 8'h10}, '{8'h10, 8'h80, 8'h80}, 1'b1, 3, 3, -1);
        run_block("single", '{8'h55}, '{8'h55}, 1'b1, 0, 0, -1);
        run_block("depth_full", '{8'h02, 8'h01, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08},
                  '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08}, 1'b0, 13, 13, -1);

        // Asynchronous reset in the middle of a sort.
        load_block('{8'hF8, 8'hF7, 8'hF6, 8'hF5, 8'hF4, 8'hF3, 8'hF2, 8'hF1}, 1'b1);
        repeat (5) tick;
        check("mid_sort_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_out_valid", {31'd0, out_valid}, 32'd0);
        check("arst_cmp_cnt", {16'd0, cmp_cnt}, 32'd0);
        tick;
        rst_n = 1'b1;
        tick;
        $display("async reset applied mid-sort, failures so far %0d", n_fail);
        run_block("after_rst", '{8'h80, 8'h83, 8'h08}, '{8'h08, 8'h80, 8'h83}, 1'b1, 3, 3, -1);

        // Synchronous clear in the middle of an unload.
        load_block('{8'h30, 8'h20, 8'h10}, 1'b1);
        sort_wait(3);
        out_ready = 1'b1;
        check("pre_clear_data0", {24'd0, out_data}, 32'h10);
        tick;
        out_ready = 1'b0;
        check("pre_clear_data1", {24'd0, out_data}, 32'h20);
        clear = 1'b1;
        tick;
        clear = 1'b0;
        check("clr_in_ready", {31'd0, in_ready}, 32'd1);
        check("clr_out_valid", {31'd0, out_valid}, 32'd0);
        check("clr_busy", {31'd0, busy}, 32'd0);
        check("clr_done", {31'd0, done}, 32'd0);
        check("clr_cmp_kept", {16'd0, cmp_cnt}, 32'd3);
        $display("clear applied mid-unload, failures so far %0d", n_fail);
        run_block("after_clear", '{8'h07, 8'h05, 8'h06}, '{8'h05, 8'h06, 8'h07}, 1'b1, 3, 3, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
